// File: rtl/fnd_pkg.sv
// Shared constants and types for the seven-segment (FND) display scan path.
// The downstream digit-select decoder also reuses these.
package fnd_pkg;

    localparam int NUM_DIGITS        = 4;
    localparam int DIGIT_W           = 2;
    localparam int BCD_W             = 4;
    localparam int DEFAULT_DIV_COUNT = 100000;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [BCD_W-1:0]   bcd_t;

endpackage

// File: rtl/fnd_prescaler.sv
// Free-running divider for the digit slots.
// It counts 0..DIV_COUNT-1 and raises tick for the last count of each slot.
module fnd_prescaler #(
    parameter int DIV_COUNT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV_COUNT);

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(DIV_COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed BCD display scanner. The optional leading-zero
// blanking feature is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int DIV_COUNT = DEFAULT_DIV_COUNT
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_DIGITS*BCD_W-1:0] i_value,
    input  logic                        i_dispOff,
    output logic [DIGIT_W-1:0]          o_digitSelect,
    output logic [BCD_W-1:0]            o_bcd,
    output logic                        o_blank,
    output logic                        o_tick
);

    digit_t                      digit;
    logic [NUM_DIGITS*BCD_W-1:0] snapshot;
    logic                        tick;

    fnd_prescaler #(
        .DIV_COUNT(DIV_COUNT)
    ) u_prescaler (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .tick (tick)
    );

    // Capture a new value only at the frame boundary, so a frame never shows a mix of two values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            digit    <= '0;
            snapshot <= '0;
        end else if (tick) begin
            digit <= digit + 1'b1;
            if (digit == digit_t'(NUM_DIGITS - 1)) begin
                snapshot <= i_value;
            end
        end
    end

    always_comb begin
        o_bcd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit == digit_t'(i)) begin
                o_bcd = snapshot[i*BCD_W +: BCD_W];
            end
        end
    end

`ifdef FND_LEADING_ZERO_BLANK_EN
    logic lz_blank;
    logic upper_zero;

    // Walk down from the top digit; upper_zero means all nibbles from i up to 3 are zero.
    always_comb begin
        lz_blank   = 1'b0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (snapshot[i*BCD_W +: BCD_W] == '0);
            if (digit == digit_t'(i) && upper_zero) begin
                lz_blank = 1'b1;
            end
        end
    end

    assign o_blank = i_dispOff | lz_blank;
`else
    assign o_blank = i_dispOff;
`endif

    assign o_digitSelect = digit;
    assign o_tick        = tick;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomised self-checking bench for fnd_scan_controller with DIV_COUNT=4.
// The reference model derives every expected output from the count of clock edges since reset release.
module tb_fnd_scan_controller;

    localparam int D = 4;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_value;
    logic        i_dispOff;
    logic [1:0]  o_digitSelect;
    logic [3:0]  o_bcd;
    logic        o_blank;
    logic        o_tick;

    int          total;
    int          bad;
    int          n;
    logic [15:0] snap;

    fnd_scan_controller #(
        .DIV_COUNT(D)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_value      (i_value),
        .i_dispOff    (i_dispOff),
        .o_digitSelect(o_digitSelect),
        .o_bcd        (o_bcd),
        .o_blank      (o_blank),
        .o_tick       (o_tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (n=%0d)", tag, actual, expected, n);
        end
    endtask

    function automatic int modelDigit();
        return (n / D) % 4;
    endfunction

    function automatic logic modelBlank();
        int d;
        logic lz;
        d  = modelDigit();
        lz = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (d >= 1 && (snap >> (4 * d)) == 16'h0) lz = 1'b1;
`endif
        return i_dispOff | lz;
    endfunction

    task automatic checkAll(input string tag);
        int d;
        d = modelDigit();
        checkOutput({tag, ".sel"},   16'(o_digitSelect), 16'(d));
        checkOutput({tag, ".bcd"},   16'(o_bcd),         16'((snap >> (4 * d)) & 16'hF));
        checkOutput({tag, ".tick"},  16'(o_tick),        16'((n % D) == D - 1));
        checkOutput({tag, ".blank"}, 16'(o_blank),       16'(modelBlank()));
    endtask

    // One clock: the model advances on the rising edge, outputs are checked on the falling edge.
    task automatic applyStimulus(input string tag);
        @(posedge i_clk);
        if (i_rst_n) begin
            n++;
            if (n % (4 * D) == 0) snap = i_value;
        end
        @(negedge i_clk);
        checkAll(tag);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        n         = 0;
        snap      = 16'h0;
        i_rst_n   = 1'b0;
        i_value   = 16'h1234;
        i_dispOff = 1'b0;

        repeat (3) applyStimulus("reset");
        i_rst_n = 1'b1;
        #1 checkAll("release");

        // First frame shows zeros, then 1234 from the first wrap onward.
        repeat (3 * 4 * D) applyStimulus("scan1234");

        while (modelDigit() != 1) applyStimulus("seek1");
        i_value = 16'h5678;
        repeat (2 * 4 * D) applyStimulus("midframe");

        i_value = 16'h0007;
        repeat (2 * 4 * D) applyStimulus("lz0007");
        i_value = 16'h0000;
        repeat (2 * 4 * D) applyStimulus("lz0000");
        i_value = 16'h0100;
        repeat (2 * 4 * D) applyStimulus("lz0100");
        i_value = 16'h00AF;
        repeat (2 * 4 * D) applyStimulus("hexnib");

        i_dispOff = 1'b1;
        #1 checkAll("offnow");
        repeat (4 * D + 3) applyStimulus("dispoff");
        i_dispOff = 1'b0;
        #1 checkAll("onnow");
        applyStimulus("dispon");

        while (modelDigit() != 2 || (n % D) != 1) applyStimulus("seek2");
        #2 i_rst_n = 1'b0;
        n    = 0;
        snap = 16'h0;
        #1 checkAll("rstmid");
        applyStimulus("inrst");
        i_rst_n = 1'b1;
        repeat (2 * 4 * D) applyStimulus("restart");

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(7) == 0) i_value = 16'($urandom);
            if ($urandom_range(3) == 0) i_value[15:8] = 8'h00;
            if ($urandom_range(5) == 0) i_dispOff = ~i_dispOff;
            applyStimulus("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named i_clk and i_rst_n.
REQ-002 Parameter DIV_COUNT SHALL default to 100000 and set the clock cycles per digit slot; the legal minimum is 2.
REQ-003 i_clk SHALL be an input, 1 bit wide, and is the system clock (rising edge).
REQ-004 i_rst_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-005 i_value SHALL be an input, 16 bits wide, carrying four BCD nibbles; [3:0] is digit 0 (least significant) and [15:12] is digit 3.
REQ-006 i_dispOff SHALL be an input, 1 bit wide; a 1 forces the display blank.
REQ-007 o_digitSelect SHALL be an output, 2 bits wide, giving the active digit index and driving the downstream digit-select decoder.
REQ-008 o_bcd SHALL be an output, 4 bits wide, giving the BCD nibble of the active digit.
REQ-009 o_blank SHALL be an output, 1 bit wide, driving the decoder enable; 1 means all digits off.
REQ-010 o_tick SHALL be an output, 1 bit wide, pulsing for one cycle on each digit-slot boundary.

Function
REQ-011 The prescaler SHALL count 0..DIV_COUNT-1 and wrap to 0, with width $clog2(DIV_COUNT).
REQ-012 o_tick SHALL be 1 exactly while prescaler == DIV_COUNT-1.
REQ-013 The digit counter SHALL advance 0->1->2->3->0 on each clock edge where o_tick=1, and hold otherwise.
REQ-014 Each digit value SHALL be held for exactly DIV_COUNT cycles, giving a frame of 4*DIV_COUNT cycles.
REQ-015 o_digitSelect SHALL equal the registered digit counter.
REQ-016 The snapshot register SHALL load i_value on the edge where the digit counter wraps 3->0, and hold otherwise.
REQ-017 Changes on i_value mid-frame SHALL never affect digits of the current frame.
REQ-018 o_bcd SHALL be snapshot[4*d+3:4*d], where d is the digit counter, combinationally from registers, so output latency is zero cycles after a digit change.
REQ-019 Nibbles 10..15 SHALL pass through on o_bcd unchanged and SHALL NOT cause blanking.
REQ-020 o_blank SHALL be 1 whenever i_dispOff=1, combinationally; scanning continues unaffected.
REQ-021 With i_dispOff=0, o_blank SHALL be 0 except for the cases in REQ-026.

Reset
REQ-022 Asserting i_rst_n=0 SHALL immediately clear the prescaler, digit counter and snapshot to 0, including when asserted mid-scan.
REQ-023 During and after reset, outputs SHALL be o_digitSelect=0, o_bcd=0, and o_tick=0, with o_blank=i_dispOff.
REQ-024 The first digit advance after reset release SHALL occur DIV_COUNT cycles after the first active edge.

Configuration
REQ-025 Macro FND_LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-026 With FND_LEADING_ZERO_BLANK_EN defined, o_blank SHALL be 1 for digit d≥1 when all snapshot nibbles d..3 are zero; digit 0 SHALL never be blanked by this rule.
REQ-027 Without FND_LEADING_ZERO_BLANK_EN, no zero blanking logic SHALL exist, and o_blank SHALL equal i_dispOff.

Structure
REQ-028 Shared package fnd_pkg SHALL hold NUM_DIGITS=4, DIGIT_W=2, BCD_W=4 and DEFAULT_DIV_COUNT=100000, and these SHALL be reused by the downstream decoder.
REQ-029 The tick generator SHALL be a sub-module fnd_prescaler (parameter DIV_COUNT, output tick); all other logic SHALL remain in fnd_scan_controller.

Verification
REQ-030 Reset check, with DIV_COUNT=4: hold reset, then release -> sel=0, bcd=0, blank=0, tick=0; first tick occurs on cycle 4.
REQ-031 Scan order: i_value=16'h1234 -> after one wrap, sel 0,1,2,3 each for 4 cycles with bcd 4,3,2,1; tick period is 4 cycles.
REQ-032 Mid-frame change: i_value changes 16'h1234->16'h5678 while sel=1 -> digits 2,3 show 2,1, then from the next wrap bcd shows 8,7,6,5.
REQ-033 Leading-zero blanking (macro on): 16'h0007 -> blank=1 on sel 3,2,1 and blank=0 with bcd=7 on sel 0; 16'h0000 -> only sel 0 unblanked; 16'h0100 -> only sel 3 blanked. With the macro off, blank=0 for all digits.
REQ-034 Display off: i_dispOff=1 -> blank=1 on every digit while sel keeps cycling; deassert -> blank drops the same cycle.
REQ-035 Reset mid-scan: assert i_rst_n=0 while sel=2 -> sel=0 and bcd=0 asynchronously; scanning restarts from digit 0 with a full DIV_COUNT slot.
